multi_cnt_led: RTL and testbench

- Parametrised N-channel free-running counter array with per-channel prescaler, direction, enable and synchronous load.
- Drives a tap window of each counter onto LEDs. It is the general successor of the board-level LED blink/counter demo.
- Sits directly behind the clocking wizard. `locked` qualifies counting, so all channels hold a known pattern until the clock is stable.
- Single clock domain.

---
 rtl/multi_cnt_led_pkg.sv | 11 +
 rtl/multi_cnt_led_ch.sv | 102 ++++++++++
 rtl/multi_cnt_led.sv | 49 ++++
 tb/tb_multi_cnt_led.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cnt_led_pkg.sv
// rtl/multi_cnt_led_pkg.sv - shared direction encodings and default counter init value
package multi_cnt_led_pkg;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam logic [31:0] INIT_VAL_DEFAULT = 32'hAAAA_AAAA;

endpackage

// File: rtl/multi_cnt_led_ch.sv
// rtl/multi_cnt_led_ch.sv - one counter channel: prescaler, up/down counter, wrap pulse
// Optional MULTI_CNT_LED_SAT_EN: saturate at the limits instead of wrapping.
module multi_cnt_led_ch
    import multi_cnt_led_pkg::*;
#(
    parameter int             CNT_W  = 32,
    parameter int             DIV_W  = 8,
    parameter logic [CNT_W-1:0] INIT_C = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             locked_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             at_lim;
    logic [CNT_W-1:0] step;
`ifdef MULTI_CNT_LED_SAT_EN
    // Set once the pulse for hitting the current limit has been issued.
    logic             lim_q, lim_d;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        tick   = 1'b0;
`ifdef MULTI_CNT_LED_SAT_EN
        lim_d  = lim_q;
`endif
        if (!locked_i) begin
            cnt_d = INIT_C;
            pre_d = '0;
`ifdef MULTI_CNT_LED_SAT_EN
            lim_d = 1'b0;
`endif
        end else if (load_i) begin
            cnt_d = load_val_i;
            pre_d = '0;
`ifdef MULTI_CNT_LED_SAT_EN
            lim_d = 1'b0;
`endif
        end else if (en_i) begin
            if (pre_q >= div_i) begin
                tick  = 1'b1;
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        at_lim = (dir_i == DIR_DN) ? (cnt_q == '0) : (cnt_q == '1);
        step   = (dir_i == DIR_DN) ? (cnt_q - 1'b1) : (cnt_q + 1'b1);

        if (tick) begin
`ifdef MULTI_CNT_LED_SAT_EN
            if (at_lim) begin
                wrap_d = !lim_q;
                lim_d  = 1'b1;
            end else begin
                cnt_d = step;
                lim_d = 1'b0;
            end
`else
            cnt_d  = step;
            wrap_d = at_lim;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= INIT_C;
            pre_q  <= '0;
            wrap_q <= 1'b0;
`ifdef MULTI_CNT_LED_SAT_EN
            lim_q  <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
`ifdef MULTI_CNT_LED_SAT_EN
            lim_q  <= lim_d;
`endif
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/multi_cnt_led.sv
// rtl/multi_cnt_led.sv - N-channel prescaled counter array with LED tap windows
// Optional MULTI_CNT_LED_SAT_EN: saturating counters (handled in multi_cnt_led_ch).
module multi_cnt_led
    import multi_cnt_led_pkg::*;
#(
    parameter int          N_CH       = 2,
    parameter int          CNT_W      = 32,
    parameter int          DIV_W      = 8,
    parameter int          LED_PER_CH = 4,
    parameter int          TAP_LSB    = 24,
    parameter logic [31:0] INIT_VAL   = INIT_VAL_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       locked,
    input  logic [N_CH-1:0]            en,
    input  logic [N_CH-1:0]            dir,
    input  logic [N_CH*DIV_W-1:0]      div,
    input  logic [N_CH-1:0]            load,
    input  logic [N_CH*CNT_W-1:0]      load_val,
    output logic [N_CH*CNT_W-1:0]      cnt,
    output logic [N_CH-1:0]            wrap,
    output logic [N_CH*LED_PER_CH-1:0] led
);

    localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_VAL);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        multi_cnt_led_ch #(
            .CNT_W  (CNT_W),
            .DIV_W  (DIV_W),
            .INIT_C (INIT_C)
        ) u_ch (
            .clk_i      (clk),
            .rst_i      (rst),
            .locked_i   (locked),
            .en_i       (en[i]),
            .dir_i      (dir[i]),
            .div_i      (div[i*DIV_W +: DIV_W]),
            .load_i     (load[i]),
            .load_val_i (load_val[i*CNT_W +: CNT_W]),
            .cnt_o      (cnt[i*CNT_W +: CNT_W]),
            .wrap_o     (wrap[i])
        );

        assign led[i*LED_PER_CH +: LED_PER_CH] = cnt[i*CNT_W + TAP_LSB +: LED_PER_CH];
    end

endmodule

// File: tb/tb_multi_cnt_led.sv
// tb/tb_multi_cnt_led.sv - directed self-checking bench for multi_cnt_led
module tb_multi_cnt_led;

    logic        clk = 1'b0;
    logic        rst;
    logic        locked;
    logic [1:0]  en;
    logic [1:0]  dir;
    logic [7:0]  div;
    logic [1:0]  load;
    logic [15:0] load_val;
    logic [15:0] cnt;
    logic [1:0]  wrap;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    multi_cnt_led #(
        .N_CH       (2),
        .CNT_W      (8),
        .DIV_W      (4),
        .LED_PER_CH (4),
        .TAP_LSB    (4),
        .INIT_VAL   (32'h0000_00AA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .en       (en),
        .dir      (dir),
        .div      (div),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .wrap     (wrap),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; locked = 1'b0; en = 2'b11; dir = 2'b00; div = 8'h00;
        load = 2'b00; load_val = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) rst = 1'b0;
            step();
            checks++;
            if (cnt !== 16'hAAAA || led !== 8'hAA || wrap !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d cnt=%h led=%h wrap=%b required cnt=aaaa led=aa wrap=00",
                         i, cnt, led, wrap);
            end
        end
    endtask

    task automatic test_lock;
        logic [15:0] exp_c [2];
        exp_c = '{16'hABAB, 16'hACAC};
        locked = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (cnt !== exp_c[i] || wrap !== 2'b00) begin
                errors++;
                $display("FAIL lock_resume cyc=%0d cnt=%h wrap=%b required cnt=%h wrap=00",
                         i, cnt, wrap, exp_c[i]);
            end
        end
    endtask

    task automatic test_prescale;
        logic [7:0] exp0 [8];
        logic [7:0] exp1 [8];
        logic [7:0] exp_led;
        exp0 = '{8'hAA, 8'hAA, 8'hAA, 8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hAC};
        exp1 = '{8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB0, 8'hB1, 8'hB2};
        rst = 1'b1;
        step();
        rst = 1'b0; div = 8'h03; en = 2'b11; dir = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_led = {exp1[i][7:4], exp0[i][7:4]};
            checks++;
            if (cnt !== {exp1[i], exp0[i]} || led !== exp_led) begin
                errors++;
                $display("FAIL prescale cyc=%0d cnt=%h led=%h required cnt=%h%h led=%h",
                         i, cnt, led, exp1[i], exp0[i], exp_led);
            end
        end
    endtask

    task automatic test_up_wrap;
        logic [7:0] exp_c [5];
        logic       exp_w [5];
`ifdef MULTI_CNT_LED_SAT_EN
        exp_c = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        exp_c = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
        en = 2'b01; div = 8'h00; dir = 2'b00;
        load = 2'b01; load_val = 16'h00FE;
        for (int i = 0; i < 5; i++) begin
            step();
            load = 2'b00;
            checks++;
            if (cnt[7:0] !== exp_c[i] || wrap[0] !== exp_w[i] || cnt[15:8] !== 8'hB2 || wrap[1] !== 1'b0) begin
                errors++;
                $display("FAIL up_wrap cyc=%0d cnt=%h wrap=%b required cnt=b2%h wrap=0%b",
                         i, cnt, wrap, exp_c[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_down_wrap;
        logic [7:0] exp_c [4];
        logic       exp_w [4];
`ifdef MULTI_CNT_LED_SAT_EN
        exp_c = '{8'h01, 8'h00, 8'h00, 8'h00};
`else
        exp_c = '{8'h01, 8'h00, 8'hFF, 8'hFE};
`endif
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
        en = 2'b10; div = 8'h00; dir = 2'b10;
        load = 2'b10; load_val = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            step();
            load = 2'b00;
            checks++;
            if (cnt[15:8] !== exp_c[i] || wrap !== {exp_w[i], 1'b0}) begin
                errors++;
                $display("FAIL down_wrap cyc=%0d cnt1=%h wrap=%b required cnt1=%h wrap=%b0",
                         i, cnt[15:8], wrap, exp_c[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_load_priority;
        logic [7:0] exp_r [3];
        exp_r = '{8'h5C, 8'h5C, 8'h5D};
        dir = 2'b00; en = 2'b01; div = 8'h02;
        load = 2'b01; load_val = 16'h00FF;
        step();
        load = 2'b00;
        step();
        step();
        checks++;
        if (cnt[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL load_setup cnt0=%h required ff", cnt[7:0]);
        end
        // Prescaler is now at its terminal count: this edge would tick and wrap.
        load = 2'b01; load_val = 16'h005C;
        step();
        load = 2'b00;
        checks++;
        if (cnt[7:0] !== 8'h5C || wrap !== 2'b00) begin
            errors++;
            $display("FAIL load_over_tick cnt0=%h wrap=%b required cnt0=5c wrap=00", cnt[7:0], wrap);
        end
        en = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (cnt[7:0] !== 8'h5C || wrap !== 2'b00) begin
                errors++;
                $display("FAIL en_low_hold cyc=%0d cnt0=%h wrap=%b required cnt0=5c wrap=00",
                         i, cnt[7:0], wrap);
            end
        end
        en = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cnt[7:0] !== exp_r[i]) begin
                errors++;
                $display("FAIL pre_restart cyc=%0d cnt0=%h required %h", i, cnt[7:0], exp_r[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        en = 2'b01; div = 8'h00; dir = 2'b00;
        load = 2'b01; load_val = 16'h00FF;
        step();
        load = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (cnt !== 16'hAAAA || wrap !== 2'b00 || led[3:0] !== 4'hA) begin
            errors++;
            $display("FAIL mid_reset cnt=%h wrap=%b led=%h required cnt=aaaa wrap=00 led[3:0]=a",
                     cnt, wrap, led);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_c [3];
        exp_c = '{16'hABAB, 16'hAAAA, 16'hABAB};
        en = 2'b11; div = 8'h00; dir = 2'b00; locked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            locked = (i != 0);
            checks++;
            if (cnt !== exp_c[i] || wrap !== 2'b00) begin
                errors++;
                $display("FAIL unlock_relock cyc=%0d cnt=%h wrap=%b required cnt=%h wrap=00",
                         i, cnt, wrap, exp_c[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; locked = 1'b0; en = 2'b00; dir = 2'b00; div = 8'h00;
        load = 2'b00; load_val = 16'h0000;
        #1;
        test_reset();
        test_lock();
        test_prescale();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
